// File: rtl/max_pool_stream.sv
// max_pool_stream: streaming multi-channel signed max-pooling unit.
// Every LENGTH accepted input beats are reduced to one output beat that holds
// the per-lane signed maximum of the window. Both ports use valid/ready.
// Optional feature macro: MAX_POOL_ARGMAX_EN adds the out_index port, which
// carries the per-lane beat position of each maximum.
//
// Handshake: a beat moves on a port only in a cycle where valid && ready.
// Valid never depends on ready of the same port. out_data and out_index hold
// their values while out_valid && !out_ready. in_ready is low only during
// clear, or when the final beat of a window would overwrite an output beat
// that has not been taken yet.
module max_pool_stream #(
    parameter int BITWIDTH = 8,
    parameter int CHANNELS = 1,
    parameter int LENGTH   = 4,
    localparam int IDXW    = (LENGTH > 1) ? $clog2(LENGTH) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [BITWIDTH*CHANNELS-1:0] in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [BITWIDTH*CHANNELS-1:0] out_data
`ifdef MAX_POOL_ARGMAX_EN
    ,
    output logic [IDXW*CHANNELS-1:0]     out_index
`endif
);

    localparam int              W    = BITWIDTH * CHANNELS;
    localparam logic [IDXW-1:0] LAST = IDXW'(LENGTH - 1);

    logic [IDXW-1:0] cnt_q, cnt_d;
    logic [W-1:0]    acc_q, acc_d;
    logic            out_valid_q, out_valid_d;
    logic [W-1:0]    out_data_q, out_data_d;
    logic [W-1:0]    win_max;
    logic            last;
    logic            accept;

`ifdef MAX_POOL_ARGMAX_EN
    logic [IDXW*CHANNELS-1:0] acc_idx_q, acc_idx_d;
    logic [IDXW*CHANNELS-1:0] out_index_q, out_index_d;
    logic [IDXW*CHANNELS-1:0] win_idx;
`endif

    // Only the final beat of a window can be held back by a full output slot.
    assign last     = (cnt_q == LAST);
    assign in_ready = !clear && !(last && out_valid_q && !out_ready);
    assign accept   = in_valid && in_ready;

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
`ifdef MAX_POOL_ARGMAX_EN
    assign out_index = out_index_q;
`endif

    // Running maximum including the current beat; the first beat of a window
    // is taken as-is so no seed constant is needed. Ties keep the older beat.
    always_comb begin
        win_max = in_data;
`ifdef MAX_POOL_ARGMAX_EN
        win_idx = '0;
`endif
        for (int c = 0; c < CHANNELS; c++) begin
`ifdef MAX_POOL_ARGMAX_EN
            win_idx[c*IDXW +: IDXW] = cnt_q;
`endif
            if ((cnt_q != '0) &&
                ($signed(acc_q[c*BITWIDTH +: BITWIDTH]) >=
                 $signed(in_data[c*BITWIDTH +: BITWIDTH]))) begin
                win_max[c*BITWIDTH +: BITWIDTH] = acc_q[c*BITWIDTH +: BITWIDTH];
`ifdef MAX_POOL_ARGMAX_EN
                win_idx[c*IDXW +: IDXW] = acc_idx_q[c*IDXW +: IDXW];
`endif
            end
        end
    end

    // Next-state: window counter, accumulator and the one-deep output slot.
    always_comb begin
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
`ifdef MAX_POOL_ARGMAX_EN
        acc_idx_d   = acc_idx_q;
        out_index_d = out_index_q;
`endif
        if (clear) begin
            cnt_d = '0;
            acc_d = '0;
`ifdef MAX_POOL_ARGMAX_EN
            acc_idx_d = '0;
`endif
        end else if (accept) begin
            acc_d = win_max;
            cnt_d = last ? '0 : cnt_q + IDXW'(1);
`ifdef MAX_POOL_ARGMAX_EN
            acc_idx_d = win_idx;
`endif
        end
        // Drain first, so a final beat landing in the same cycle wins.
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (accept && last) begin
            out_valid_d = 1'b1;
            out_data_d  = win_max;
`ifdef MAX_POOL_ARGMAX_EN
            out_index_d = win_idx;
`endif
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
`ifdef MAX_POOL_ARGMAX_EN
            acc_idx_q   <= '0;
            out_index_q <= '0;
`endif
        end else begin
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
`ifdef MAX_POOL_ARGMAX_EN
            acc_idx_q   <= acc_idx_d;
            out_index_q <= out_index_d;
`endif
        end
    end

endmodule

// File: tb/tb_max_pool_stream.sv
// Bench for max_pool_stream: a CHANNELS=2/LENGTH=4 instance driven by a
// directed vector table, hand sequences for reset, and random traffic checked
// against a window-array reference model; plus a LENGTH=1 instance.
module tb_max_pool_stream;

  localparam int BW  = 8;
  localparam int CH  = 2;
  localparam int LEN = 4;
  localparam int W   = BW * CH;
  localparam int IW  = 2;

  logic clk = 1'b0;
  logic rst;

  logic          clear, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]  in_data, out_data;
  logic [IW*CH-1:0] out_index;

  logic          l1_clear, l1_in_valid, l1_in_ready, l1_out_valid, l1_out_ready;
  logic [BW-1:0] l1_in_data, l1_out_data;
  logic [0:0]    l1_out_index;

  int n_checks = 0;
  int n_errors = 0;

  // clock / reset block
  always #5 clk = ~clk;

  max_pool_stream #(.BITWIDTH(BW), .CHANNELS(CH), .LENGTH(LEN)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef MAX_POOL_ARGMAX_EN
    , .out_index(out_index)
`endif
  );

  max_pool_stream #(.BITWIDTH(BW), .CHANNELS(1), .LENGTH(1)) dut_l1 (
    .clk(clk), .rst(rst), .clear(l1_clear),
    .in_valid(l1_in_valid), .in_ready(l1_in_ready), .in_data(l1_in_data),
    .out_valid(l1_out_valid), .out_ready(l1_out_ready), .out_data(l1_out_data)
`ifdef MAX_POOL_ARGMAX_EN
    , .out_index(l1_out_index)
`endif
  );

`ifndef MAX_POOL_ARGMAX_EN
  assign out_index    = '0;
  assign l1_out_index = '0;
`endif

  typedef struct {
    logic          v;
    logic [W-1:0]  d;
    logic          r;
    logic          c;
    logic          e_rdy;
    logic          e_ov;
    logic [W-1:0]  e_od;
    logic [IW*CH-1:0] e_idx;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic [W-1:0] d, input logic r, input logic c,
                     input logic e_rdy, input logic e_ov, input logic [W-1:0] e_od,
                     input logic [IW*CH-1:0] e_idx);
    vec_t t;
    t.v = v; t.d = d; t.r = r; t.c = c;
    t.e_rdy = e_rdy; t.e_ov = e_ov; t.e_od = e_od; t.e_idx = e_idx;
    vecs.push_back(t);
  endtask

  // driver: entered just after a rising edge; samples in_ready before the
  // next edge and the output port 1 time unit after it
  task automatic apply(input logic v, input logic [W-1:0] d, input logic r, input logic c,
                       output logic rdy, output logic ov, output logic [W-1:0] od,
                       output logic [IW*CH-1:0] oi);
    in_valid = v; in_data = d; out_ready = r; clear = c;
    #1;
    rdy = in_ready;
    @(posedge clk);
    #1;
    ov = out_valid; od = out_data; oi = out_index;
  endtask

  // reference model: raw beats of the open window, maxima found on completion
  logic signed [BW-1:0] win [CH][LEN];
  int               win_n;
  logic             m_ov;
  logic [W-1:0]     m_od;
  logic [IW*CH-1:0] m_idx;

  task automatic model_reset();
    win_n = 0; m_ov = 1'b0; m_od = '0; m_idx = '0;
  endtask

  task automatic model_step(input logic v, input logic [W-1:0] d, input logic r,
                            input logic c, output logic exp_rdy);
    logic signed [BW-1:0] best;
    int bi;
    exp_rdy = !c && !((win_n == LEN - 1) && m_ov && !r);
    if (m_ov && r) m_ov = 1'b0;
    if (c) begin
      win_n = 0;
    end else if (v && exp_rdy) begin
      for (int l = 0; l < CH; l++) win[l][win_n] = d[l*BW +: BW];
      win_n++;
      if (win_n == LEN) begin
        for (int l = 0; l < CH; l++) begin
          best = win[l][0]; bi = 0;
          for (int k = 1; k < LEN; k++)
            if (win[l][k] > best) begin best = win[l][k]; bi = k; end
          m_od[l*BW +: BW] = best;
          m_idx[l*IW +: IW] = IW'(bi);
        end
        m_ov = 1'b1;
        win_n = 0;
      end
    end
  endtask

  initial begin
    logic rdy, ov, erdy;
    logic [W-1:0] od;
    logic [IW*CH-1:0] oi;
    logic [W-1:0] d;

    rst = 1'b1;
    clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    l1_clear = 1'b0; l1_in_valid = 1'b0; l1_in_data = '0; l1_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset out_data", {16'd0, out_data}, 32'd0);
    check("reset in_ready", {31'd0, in_ready}, 32'd1);
`ifdef MAX_POOL_ARGMAX_EN
    check("reset out_index", {28'd0, out_index}, 32'd0);
`endif
    @(posedge clk);
    #1;

    // basic max 3,-5,7,2 on both lanes
    add(1, 16'h0303, 1, 0, 1, 0, 16'h0000, 4'h0);
    add(1, 16'hFBFB, 1, 0, 1, 0, 16'h0000, 4'h0);
    add(1, 16'h0707, 1, 0, 1, 0, 16'h0000, 4'h0);
    add(1, 16'h0202, 1, 0, 1, 1, 16'h0707, 4'b1010);
    add(0, 16'h0000, 1, 0, 1, 0, 16'h0000, 4'h0);
    // most negative and ties: lane0 -128 x4, lane1 5,9,9,1
    add(1, 16'h0580, 1, 0, 1, 0, 16'h0000, 4'h0);
    add(1, 16'h0980, 1, 0, 1, 0, 16'h0000, 4'h0);
    add(1, 16'h0980, 1, 0, 1, 0, 16'h0000, 4'h0);
    add(1, 16'h0180, 1, 0, 1, 1, 16'h0980, 4'b0100);
    // backpressure: first result held, final beat of window 2 stalls
    add(0, 16'h0000, 0, 0, 1, 1, 16'h0980, 4'b0100);
    add(1, 16'h0101, 0, 0, 1, 1, 16'h0980, 4'b0100);
    add(1, 16'h0202, 0, 0, 1, 1, 16'h0980, 4'b0100);
    add(1, 16'h0303, 0, 0, 1, 1, 16'h0980, 4'b0100);
    add(1, 16'h0404, 0, 0, 0, 1, 16'h0980, 4'b0100);
    add(1, 16'h0404, 0, 0, 0, 1, 16'h0980, 4'b0100);
    add(1, 16'h0404, 1, 0, 1, 1, 16'h0404, 4'b1111);
    add(0, 16'h0000, 1, 0, 1, 0, 16'h0000, 4'h0);
    // clear mid-window: 100, 50, clear, then -1,-2,-3,-4
    add(1, 16'h6464, 1, 0, 1, 0, 16'h0000, 4'h0);
    add(1, 16'h3232, 1, 0, 1, 0, 16'h0000, 4'h0);
    add(1, 16'h7F7F, 1, 1, 0, 0, 16'h0000, 4'h0);
    add(1, 16'hFFFF, 1, 0, 1, 0, 16'h0000, 4'h0);
    add(1, 16'hFEFE, 1, 0, 1, 0, 16'h0000, 4'h0);
    add(1, 16'hFDFD, 1, 0, 1, 0, 16'h0000, 4'h0);
    add(1, 16'hFCFC, 1, 0, 1, 1, 16'hFFFF, 4'h0);
    add(0, 16'h0000, 1, 0, 1, 0, 16'h0000, 4'h0);
    // clear leaves a pending output untouched
    add(1, 16'h0102, 0, 0, 1, 0, 16'h0000, 4'h0);
    add(1, 16'h0102, 0, 0, 1, 0, 16'h0000, 4'h0);
    add(1, 16'h0102, 0, 0, 1, 0, 16'h0000, 4'h0);
    add(1, 16'h0102, 0, 0, 1, 1, 16'h0102, 4'h0);
    add(1, 16'h7777, 0, 1, 0, 1, 16'h0102, 4'h0);
    add(0, 16'h0000, 1, 0, 1, 0, 16'h0000, 4'h0);

    foreach (vecs[i]) begin
      apply(vecs[i].v, vecs[i].d, vecs[i].r, vecs[i].c, rdy, ov, od, oi);
      check($sformatf("vec%0d in_ready", i), {31'd0, rdy}, {31'd0, vecs[i].e_rdy});
      check($sformatf("vec%0d out_valid", i), {31'd0, ov}, {31'd0, vecs[i].e_ov});
      if (vecs[i].e_ov) begin
        check($sformatf("vec%0d out_data", i), {16'd0, od}, {16'd0, vecs[i].e_od});
`ifdef MAX_POOL_ARGMAX_EN
        check($sformatf("vec%0d out_index", i), {28'd0, oi}, {28'd0, vecs[i].e_idx});
`endif
      end
    end

    // async reset mid-window: two large beats then reset between edges
    apply(1, 16'h5050, 1, 0, rdy, ov, od, oi);
    apply(1, 16'h5050, 1, 0, rdy, ov, od, oi);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst mid-window out_valid", {31'd0, out_valid}, 32'd0);
    check("rst mid-window in_ready", {31'd0, in_ready}, 32'd1);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    apply(1, 16'h0101, 1, 0, rdy, ov, od, oi);
    apply(1, 16'h0202, 1, 0, rdy, ov, od, oi);
    apply(1, 16'h0303, 1, 0, rdy, ov, od, oi);
    check("post-rst window not early", {31'd0, ov}, 32'd0);
    apply(1, 16'h0404, 1, 0, rdy, ov, od, oi);
    check("post-rst window valid", {31'd0, ov}, 32'd1);
    check("post-rst window data", {16'd0, od}, 32'h0404);

    // async reset while a result is held under backpressure
    apply(1, 16'h1111, 1, 0, rdy, ov, od, oi);
    apply(1, 16'h2222, 0, 0, rdy, ov, od, oi);
    apply(1, 16'h3333, 0, 0, rdy, ov, od, oi);
    apply(1, 16'h4444, 0, 0, rdy, ov, od, oi);
    check("held result valid", {31'd0, ov}, 32'd1);
    check("held result data", {16'd0, od}, 32'h4444);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst held out_valid", {31'd0, out_valid}, 32'd0);
    check("rst held out_data", {16'd0, out_data}, 32'd0);
`ifdef MAX_POOL_ARGMAX_EN
    check("rst held out_index", {28'd0, out_index}, 32'd0);
`endif
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // LENGTH=1 instance: 4, -4, 0 pass straight through, then idle
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      logic [BW-1:0] vals [3];
      vals[0] = 8'h04; vals[1] = 8'hFC; vals[2] = 8'h00;
      l1_in_valid = 1'b1; l1_in_data = vals[i]; l1_out_ready = 1'b1;
      #1;
      check($sformatf("len1 beat%0d in_ready", i), {31'd0, l1_in_ready}, 32'd1);
      @(posedge clk);
      #1;
      check($sformatf("len1 beat%0d out_valid", i), {31'd0, l1_out_valid}, 32'd1);
      check($sformatf("len1 beat%0d out_data", i), {24'd0, l1_out_data}, {24'd0, vals[i]});
`ifdef MAX_POOL_ARGMAX_EN
      check($sformatf("len1 beat%0d out_index", i), {31'd0, l1_out_index}, 32'd0);
`endif
    end
    l1_in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("len1 idle out_valid", {31'd0, l1_out_valid}, 32'd0);

    // random traffic against the reference model (DUT output slot empty here)
    model_reset();
    for (int i = 0; i < 400; i++) begin
      logic rv, rr, rc;
      rv = ($urandom_range(0, 3) != 0);
      rr = ($urandom_range(0, 2) != 0);
      rc = ($urandom_range(0, 19) == 0);
      for (int l = 0; l < CH; l++) begin
        case ($urandom_range(0, 5))
          0:       d[l*BW +: BW] = 8'h80;
          1:       d[l*BW +: BW] = 8'h7F;
          default: d[l*BW +: BW] = BW'($urandom);
        endcase
      end
      model_step(rv, d, rr, rc, erdy);
      apply(rv, d, rr, rc, rdy, ov, od, oi);
      check($sformatf("rand%0d in_ready", i), {31'd0, rdy}, {31'd0, erdy});
      check($sformatf("rand%0d out_valid", i), {31'd0, ov}, {31'd0, m_ov});
      if (m_ov) begin
        check($sformatf("rand%0d out_data", i), {16'd0, od}, {16'd0, m_od});
`ifdef MAX_POOL_ARGMAX_EN
        check($sformatf("rand%0d out_index", i), {28'd0, oi}, {28'd0, m_idx});
`endif
      end
    end

    // final report
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/max_pool_stream.md
# max_pool_stream

Streaming, multi-channel signed max-pooling unit for the CNN datapath. It takes one beat of CHANNELS signed samples per accepted handshake and reduces every LENGTH consecutive beats to one beat of per-channel maxima. Both sides use valid/ready handshakes. It sits between a convolution/activation stage and the next layer's input buffer, and is the sequential, parametrised successor to the combinational max reducer.

## Interface
- BITWIDTH, 8: width of one signed two's-complement sample.
- CHANNELS, 1: number of independent lanes per beat; lane c occupies bits [c*BITWIDTH +: BITWIDTH].
- LENGTH, 4: beats per pooling window; must be >= 1.
- IDXW (localparam): $clog2(LENGTH), or 1 if LENGTH == 1.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous flush of the partial window.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_data  in  BITWIDTH*CHANNELS  input samples.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  BITWIDTH*CHANNELS  per-lane window maxima.
- out_index  out  IDXW*CHANNELS  per-lane beat position of the maximum; present only with MAX_POOL_ARGMAX_EN.

## Operation
- Internal state:
  - beat counter cnt, range 0..LENGTH-1;
  - per-lane accumulator acc;
  - one-deep output register.
- Accepted beat with cnt == 0: acc is loaded directly from in_data; there is no seed constant, so the most negative value -2^(BITWIDTH-1) is handled correctly.
- Accepted beat with cnt > 0: per lane, acc = (in > acc) ? in : acc, using a signed compare. On a tie the earlier beat is kept.
- Accepted beat with cnt == LENGTH-1:
  - the lane maxima, including the current beat, are written to out_data;
  - out_valid is set;
  - cnt returns to 0.
- Otherwise an accepted beat increments cnt.
- in_ready = !clear && !(cnt == LENGTH-1 && out_valid && !out_ready). Non-final beats are never stalled by the output.
- Output handshake:
  - out_valid clears on out_valid && out_ready, unless a new final beat is accepted in the same cycle, in which case it stays 1 with the new data.
  - out_data and out_index are held stable while out_valid && !out_ready.
- clear:
  - sets cnt to 0 and discards the partial acc;
  - any in_data presented in that cycle is not accepted (in_ready = 0);
  - a pending output beat is unaffected.
- LENGTH == 1: every accepted beat is passed to the output register unchanged; out_index is 0.

## Timing
- Reset values: in_ready 1, out_valid 0, out_data 0, out_index 0, cnt 0, acc 0.
- Latency: out_valid rises on the clock edge that accepts the final beat of the window, so it is visible the following cycle.
- Throughput: one beat per cycle sustained while out_ready is held high; no bubbles between windows.
- Backpressure: only the final beat of a window can stall. It waits until the output slot is free or is being drained in the same cycle.
- rst asserted mid-window: all state returns to reset values immediately, and both the partial window and any pending output are lost.
- clear and rst are independent; rst dominates.

## Configuration
- MAX_POOL_ARGMAX_EN defined:
  - out_index exists;
  - per lane it carries the cnt value of the beat that produced the maximum (lowest beat index on ties);
  - it is registered alongside out_data with identical handshake timing.
- MAX_POOL_ARGMAX_EN undefined: the out_index port and its index registers are absent; all other behaviour is identical.

## Test plan
- Basic max, BITWIDTH=8, CHANNELS=1, LENGTH=4, out_ready=1:
  - stimulus: in 3, -5, 7, 2;
  - required: one out_valid pulse one cycle after the 4th beat; out_data=7; out_index=2.
- Most negative values and ties, CHANNELS=2:
  - stimulus: lane0 = -128, -128, -128, -128; lane1 = 5, 9, 9, 1;
  - required: out_data lane0 = -128, lane1 = 9; out_index lane0 = 0, lane1 = 1.
- Backpressure: hold out_ready=0 after the first result and stream 8 beats.
  - 2nd window beats 0-2 are accepted; in_ready drops on the final beat;
  - the first result stays stable;
  - raising out_ready for one cycle drains the first result and accepts the final beat in that same cycle; the second result appears the next cycle.
- clear mid-window:
  - stimulus: in 100, 50, then clear for one cycle, then -1, -2, -3, -4;
  - required: out_data=-1 (the 100 is discarded); the beat presented during clear is not accepted.
- Async reset: assert rst mid-window and while out_valid=1 with out_ready=0.
  - outputs go to reset values without waiting for a clock edge;
  - the next full window produces a correct result.
- LENGTH=1: a stream of 4, -4, 0 with out_ready=1 gives out_data 4, -4, 0 on consecutive cycles with no stall.
